pipe_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It tracks the destination-register state of the EX, MEM and WB slots and drives the pipeline-register write enables. It resolves load-use stalls, taken-branch/jump flushes and data-memory wait freezes, and produces registered forwarding selects for the EX operands. It sits beside the ID stage and consumes its decoded rs1/rs2/rd/opcode/wr_reg_n.

---
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing control for the 5-stage RV32I pipeline.
//
// Tracks the destination-register state {v, rd, wr_n, ld} of the EX (_p0),
// MEM (_p1) and WB (_p2) slots. From that state and the decoded ID
// instruction it drives the pipeline write enables, detects load-use stalls,
// applies branch/jump flushes and data-memory freezes, and registers the EX
// operand forwarding selects.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_valid              IF/ID holds a real instruction
//   id_rs1/id_rs2         ID source registers, id_use_rs1/id_use_rs2 read flags
//   id_rd, id_wr_reg_n    ID destination and its active-low write flag
//   id_opcode             ID opcode (load = 7'b0000011)
//   ex_br_taken           control transfer in EX redirects the PC
//   dmem_busy             MEM-stage data access not complete
//   pc_we, if_id_we       PC and IF/ID write enables
//   if_id_flush           IF/ID loads a bubble
//   id_ex_bubble          ID/EX loads a bubble instead of ID contents
//   ex_valid/mem_valid/wb_valid  slot valid bits
//   fwd_a/fwd_b           EX operand selects: 00 regfile, 01 MEM, 10 WB
//   stall_cnt             saturating count of load-use stall cycles
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_reg_n,
  input  logic [6:0]       id_opcode,
  input  logic             ex_br_taken,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    M_NORMAL,
    M_FREEZE,
    M_FLUSH,
    M_STALL
  } mode_t;

  // Slot state: _p0 = EX, _p1 = MEM, _p2 = WB
  logic             v_p0, v_p1, v_p2;
  logic [4:0]       rd_p0, rd_p1, rd_p2;
  logic             wr_n_p0, wr_n_p1, wr_n_p2;
  logic             ld_p0, ld_p1, ld_p2;
  logic [1:0]       fwd_a_p0, fwd_b_p0;
  logic [CNT_W-1:0] stall_cnt_r;

  mode_t      mode;
  logic       load_use;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // A slot produces register r only if it is live, writes, and r is not x0.
  function automatic logic hit(input logic v, input logic wr_n,
                               input logic [4:0] rd, input logic [4:0] r);
    return v && !wr_n && (rd != 5'd0) && (rd == r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Youngest producer (EX, forwarded from MEM next cycle) wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic ex_hit, input logic mem_hit);
    if (use_r && ex_hit)       return 2'b01;
    else if (use_r && mem_hit) return 2'b10;
    else                       return 2'b00;
  endfunction

  always_comb begin
    load_use = id_valid && ld_p0 &&
               ((id_use_rs1 && hit(v_p0, wr_n_p0, rd_p0, id_rs1)) ||
                (id_use_rs2 && hit(v_p0, wr_n_p0, rd_p0, id_rs2)));

    if (dmem_busy)        mode = M_FREEZE;
    else if (ex_br_taken) mode = M_FLUSH;
    else if (load_use)    mode = M_STALL;
    else                  mode = M_NORMAL;

    fwd_a_nxt = fwd_sel(id_use_rs1, id_rs1,
                        hit(v_p0, wr_n_p0, rd_p0, id_rs1),
                        hit(v_p1, wr_n_p1, rd_p1, id_rs1));
    fwd_b_nxt = fwd_sel(id_use_rs2, id_rs2,
                        hit(v_p0, wr_n_p0, rd_p0, id_rs2),
                        hit(v_p1, wr_n_p1, rd_p1, id_rs2));
  end

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    if (rst_n) begin
      unique case (mode)
        M_FREEZE: id_ex_bubble = 1'b0;
        M_FLUSH: begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
        end
        M_STALL: id_ex_bubble = 1'b1;
        default: begin
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          id_ex_bubble = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_p0 <= 1'b0; rd_p0 <= 5'd0; wr_n_p0 <= 1'b1; ld_p0 <= 1'b0;
      v_p1 <= 1'b0; rd_p1 <= 5'd0; wr_n_p1 <= 1'b1; ld_p1 <= 1'b0;
      v_p2 <= 1'b0; rd_p2 <= 5'd0; wr_n_p2 <= 1'b1; ld_p2 <= 1'b0;
      fwd_a_p0    <= 2'b00;
      fwd_b_p0    <= 2'b00;
      stall_cnt_r <= '0;
    end else if (mode != M_FREEZE) begin
      // ---- MEM -> WB ----
      v_p2 <= v_p1; rd_p2 <= rd_p1; wr_n_p2 <= wr_n_p1; ld_p2 <= ld_p1;
      // ---- EX -> MEM ----
      v_p1 <= v_p0; rd_p1 <= rd_p0; wr_n_p1 <= wr_n_p0; ld_p1 <= ld_p0;
      // ---- ID -> EX ----
      if (mode == M_NORMAL) begin
        v_p0     <= id_valid;
        rd_p0    <= id_rd;
        wr_n_p0  <= id_wr_reg_n;
        ld_p0    <= (id_opcode == OP_LOAD);
        fwd_a_p0 <= fwd_a_nxt;
        fwd_b_p0 <= fwd_b_nxt;
      end else begin
        v_p0     <= 1'b0;
        rd_p0    <= 5'd0;
        wr_n_p0  <= 1'b1;
        ld_p0    <= 1'b0;
        fwd_a_p0 <= 2'b00;
        fwd_b_p0 <= 2'b00;
      end
      if (mode == M_STALL) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign ex_valid  = v_p0;
  assign mem_valid = v_p1;
  assign wb_valid  = v_p2;
  assign fwd_a     = fwd_a_p0;
  assign fwd_b     = fwd_b_p0;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic clk;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_wr_reg_n, ex_br_taken, dmem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [6:0] id_opcode;

  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_valid, mem_valid, wb_valid;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic pc_we2, if_id_we2, if_id_flush2, id_ex_bubble2, ex_valid2, mem_valid2, wb_valid2;
  logic [1:0] fwd_a2, fwd_b2;
  logic [1:0] stall_cnt2;

  pipe_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_wr_reg_n(id_wr_reg_n), .id_opcode(id_opcode), .ex_br_taken(ex_br_taken),
    .dmem_busy(dmem_busy), .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_wr_reg_n(id_wr_reg_n), .id_opcode(id_opcode), .ex_br_taken(ex_br_taken),
    .dmem_busy(dmem_busy), .pc_we(pc_we2), .if_id_we(if_id_we2), .if_id_flush(if_id_flush2),
    .id_ex_bubble(id_ex_bubble2), .ex_valid(ex_valid2), .mem_valid(mem_valid2),
    .wb_valid(wb_valid2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the three in-flight instructions, youngest first.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr_n;
    logic       ld;
  } slot_t;

  slot_t      pipe [3];
  logic [1:0] m_fa, m_fb;
  int         m_stalls;

  // Combinational outputs sampled just before the last clock edge.
  logic c_pc_we, c_if_id_we, c_flush, c_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic produces(input slot_t s, input logic [4:0] r);
    return s.v && !s.wr_n && r != 5'd0 && s.rd == r;
  endfunction

  function automatic logic [1:0] model_fwd(input logic use_r, input logic [4:0] r);
    if (use_r && produces(pipe[0], r)) return 2'b01;
    if (use_r && produces(pipe[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic wrn, input logic [6:0] op, input logic br,
                      input logic busy);
    logic lu, e_pc, e_ifid, e_fl, e_bub;
    logic [1:0] nfa, nfb;
    slot_t bubble;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_wr_reg_n = wrn; id_opcode = op; ex_br_taken = br; dmem_busy = busy;
    #1;
    lu = v && pipe[0].ld && ((u1 && produces(pipe[0], rs1)) || (u2 && produces(pipe[0], rs2)));
    if (!rst_n)     begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
    else if (busy)  begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; end
    else if (br)    begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1; end
    else if (lu)    begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
    else            begin e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; end
    c_pc_we = pc_we; c_if_id_we = if_id_we; c_flush = if_id_flush; c_bubble = id_ex_bubble;
    chk("pc_we", pc_we, e_pc);
    chk("if_id_we", if_id_we, e_ifid);
    chk("if_id_flush", if_id_flush, e_fl);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("pc_we_w2", pc_we2, e_pc);
    nfa = model_fwd(u1, rs1);
    nfb = model_fwd(u2, rs2);
    @(posedge clk);
    bubble = '{v: 1'b0, rd: 5'd0, wr_n: 1'b1, ld: 1'b0};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble;
      m_fa = 2'b00; m_fb = 2'b00; m_stalls = 0;
    end else if (!busy) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (!br && !lu) begin
        pipe[0] = '{v: v, rd: rd, wr_n: wrn, ld: (op == OP_LD)};
        m_fa = nfa; m_fb = nfb;
      end else begin
        pipe[0] = bubble;
        m_fa = 2'b00; m_fb = 2'b00;
      end
      if (!br && lu) m_stalls++;
    end
    #1;
    chk("ex_valid", ex_valid, pipe[0].v);
    chk("mem_valid", mem_valid, pipe[1].v);
    chk("wb_valid", wb_valid, pipe[2].v);
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("stall_cnt", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
    chk("stall_cnt_w2", stall_cnt2, (m_stalls > 3) ? 3 : m_stalls);
    @(negedge clk);
  endtask

  // ID-stage instruction helpers
  task automatic nop_cycle(input logic busy);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, OP_I, 1'b0, busy);
  endtask

  task automatic load_use_pair(input logic [4:0] rd);
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, rd, 1'b0, OP_LD, 1'b0, 1'b0);
    step(1'b1, rd, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, OP_I, 1'b0, 1'b0);
    step(1'b1, rd, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, OP_I, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, rd: 5'd0, wr_n: 1'b1, ld: 1'b0};
    m_fa = 2'b00; m_fb = 2'b00; m_stalls = 0;
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_wr_reg_n = 1; id_opcode = OP_I; ex_br_taken = 0; dmem_busy = 0;
    @(negedge clk);

    // Reset held two cycles with a valid ID instruction
    rst_n = 1'b0;
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, OP_R, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, OP_R, 1'b0, 1'b0);
    chk("rst_pc_we", c_pc_we, 1'b0);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    rst_n = 1'b1;

    // ADD x3,x1,x2 ; ADD x4,x3,x3
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, OP_R, 1'b0, 1'b0);
    chk("release_pc_we", c_pc_we, 1'b1);
    step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, OP_R, 1'b0, 1'b0);
    chk("raw_no_stall", c_pc_we, 1'b1);
    chk("raw_fwd_a", fwd_a, 2'b01);
    chk("raw_fwd_b", fwd_b, 2'b01);

    // LB x3 ; ADDI x5,x3,1 (held in ID across the stall)
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, OP_LD, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, OP_I, 1'b0, 1'b0);
    chk("lu_pc_we", c_pc_we, 1'b0);
    chk("lu_if_id_we", c_if_id_we, 1'b0);
    chk("lu_bubble", c_bubble, 1'b1);
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, OP_I, 1'b0, 1'b0);
    chk("lu_resume_pc_we", c_pc_we, 1'b1);
    chk("lu_fwd_a", fwd_a, 2'b10);
    chk("lu_ex_valid", ex_valid, 1'b1);

    // Taken branch in EX with a valid ID instruction
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, OP_I, 1'b1, 1'b0);
    chk("br_flush", c_flush, 1'b1);
    chk("br_bubble", c_bubble, 1'b1);
    chk("br_ex_valid", ex_valid, 1'b0);
    chk("br_mem_valid", mem_valid, 1'b1);

    // Load-use pattern frozen by dmem_busy for three cycles
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, OP_LD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, OP_I, 1'b1, 1'b1);
      chk("frz_pc_we", c_pc_we, 1'b0);
      chk("frz_if_id_we", c_if_id_we, 1'b0);
      chk("frz_bubble", c_bubble, 1'b0);
      chk("frz_ex_valid", ex_valid, 1'b1);
      chk("frz_stall_cnt", stall_cnt, 16'd1);
    end
    step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, OP_I, 1'b0, 1'b0);
    chk("frz_then_stall", c_bubble, 1'b1);
    chk("frz_then_cnt", stall_cnt, 16'd2);
    step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, OP_I, 1'b0, 1'b0);
    chk("frz_then_fwd", fwd_a, 2'b10);

    // x0 is never a hazard: JAL x0 then reader; LB x0 then reader
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, OP_JAL, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, OP_I, 1'b0, 1'b0);
    chk("x0_fwd_a", fwd_a, 2'b00);
    chk("x0_fwd_b", fwd_b, 2'b00);
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, OP_LD, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0, OP_I, 1'b0, 1'b0);
    chk("x0_no_stall", c_pc_we, 1'b1);

    // Five more load-use stalls: the 2-bit counter saturates
    for (int i = 0; i < 5; i++) load_use_pair(5'd8);
    chk("sat_cnt16", stall_cnt, 16'd7);
    chk("sat_cnt2", stall_cnt2, 2'd3);
    nop_cycle(1'b0);

    // Randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      step($urandom_range(0, 7) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0) ? OP_LD : OP_R,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
